// File: rtl/ffn_cfg_loader.sv
// ffn_cfg_loader: streams W1, b1, W2, b2 words into the ffn cfg port and gates compute valid until a full load completes.
module ffn_cfg_loader #(
    parameter int EMB    = 64,
    parameter int FF     = 256,
    parameter int DATA_W = 16,
    parameter int ADDR_W = $clog2(EMB*FF + FF + FF*EMB + EMB)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              cfg_we,
    output logic [ADDR_W-1:0] cfg_addr,
    output logic [DATA_W-1:0] cfg_wdata,
    output logic [1:0]        region,
    output logic              busy,
    output logic              done,
    output logic              loaded,
    input  logic              ffn_valid_in,
    output logic              ffn_valid_out,
    output logic              gate_drop
);
    localparam int B1_BASE = EMB*FF;
    localparam int W2_BASE = B1_BASE + FF;
    localparam int B2_BASE = W2_BASE + FF*EMB;
    localparam int TOTAL   = B2_BASE + EMB;

    typedef enum logic [2:0] {IDLE, S_W1, S_B1, S_W2, S_B2} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] cnt;
    logic              accept, start_ok, last;

    assign busy          = state != IDLE;
    assign s_ready       = busy && !abort;
    assign accept        = s_valid && s_ready;
    assign start_ok      = state == IDLE && start && !abort;
    assign last          = state == S_B2 && cnt == ADDR_W'(TOTAL - 1);
    assign ffn_valid_out = ffn_valid_in && loaded && !busy;
    assign gate_drop     = ffn_valid_in && !ffn_valid_out;

    always_comb begin
        region = state == S_B1 ? 2'd1 : state == S_W2 ? 2'd2 : state == S_B2 ? 2'd3 : 2'd0;
    end

    // Region changes on acceptance of the last word of the current region.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (start_ok) state_n = S_W1;
            S_W1: if (accept && cnt == ADDR_W'(B1_BASE - 1)) state_n = S_B1;
            S_B1: if (accept && cnt == ADDR_W'(W2_BASE - 1)) state_n = S_W2;
            S_W2: if (accept && cnt == ADDR_W'(B2_BASE - 1)) state_n = S_B2;
            S_B2: if (accept && last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (busy && abort) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cfg_we    <= 1'b0;
            cfg_addr  <= '0;
            cfg_wdata <= '0;
            done      <= 1'b0;
            loaded    <= 1'b0;
        end else begin
            state  <= state_n;
            cfg_we <= accept;
            done   <= accept && last;
            cnt    <= start_ok ? '0 : accept ? cnt + 1'b1 : cnt;
            if (accept) begin
                cfg_addr  <= cnt;
                cfg_wdata <= s_data;
            end
            if (start_ok || (busy && abort))
                loaded <= 1'b0;
            else if (accept && last)
                loaded <= 1'b1;
        end
    end
endmodule

// File: doc/ffn_cfg_loader.md
Name: ffn_cfg_loader

Overview:
Sequences the weight/bias load of the FFN block's configuration port (cfg_we/cfg_addr/cfg_wdata) from a ready/valid word stream. The load order is W1, then b1, then W2, then b2, into one contiguous address space. The block also gates the FFN's valid_in so that compute traffic only passes once a complete load has finished. It sits between the host/DMA weight stream and the ffn instance in the transformer layer.

Parameters:
EMB, 64, embedding width; W1 is EMB*FF words, b2 is EMB words.
FF, 256, hidden width; b1 is FF words, W2 is FF*EMB words.
DATA_W, 16, signed weight word width.
ADDR_W, $clog2(EMB*FF+FF+FF*EMB+EMB), cfg address width (derived; must match ffn cfg_addr).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a full load
abort  in  1  cancel the load in progress
s_valid  in  1  stream word valid
s_ready  out  1  stream word ready (combinational)
s_data  in  DATA_W  stream word
cfg_we  out  1  registered write strobe to ffn
cfg_addr  out  ADDR_W  registered write address
cfg_wdata  out  DATA_W  registered write data
region  out  2  current region: 0=W1, 1=b1, 2=W2, 3=b2 (valid while busy)
busy  out  1  load in progress
done  out  1  one-cycle pulse on the final write
loaded  out  1  level; a complete load has finished and no reload has started since
ffn_valid_in  in  1  upstream compute valid
ffn_valid_out  out  1  gated valid to ffn (combinational)
gate_drop  out  1  ffn_valid_in was blocked this cycle (combinational)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - cfg_we, cfg_addr, cfg_wdata, region, busy, done, loaded all 0.
  - s_ready=0 and ffn_valid_out=0 immediately.
- FSM states: IDLE, W1, B1, W2, B2.
- Region base addresses: W1=0, B1=EMB*FF, W2=EMB*FF+FF, B2=EMB*FF+FF+FF*EMB.
- Start:
  - IDLE and start=1 and abort=0: next state W1, address counter=0, loaded cleared to 0, busy=1.
  - start while busy is ignored.
- Stream handshake:
  - s_ready = busy && !abort.
  - A beat is accepted when s_valid && s_ready.
- Write timing:
  - Each accepted beat produces cfg_we=1 on the following cycle, with cfg_addr = counter value at acceptance and cfg_wdata = s_data.
  - Latency is 1 cycle.
  - On cycles with no accepted beat, cfg_we=0. cfg_addr and cfg_wdata hold their last values.
- Counter and region sequencing:
  - The counter increments by 1 per accepted beat. Addresses are strictly sequential with no gaps, regardless of s_valid bubbles.
  - Region advances when the beat at the last address of a region is accepted: W1→B1→W2→B2.
  - The region output follows the state.
- End of load:
  - Accepting the last B2 beat returns the FSM to IDLE.
  - On the next cycle busy=0 and loaded=1, and done pulses for exactly one cycle, coincident with the final cfg_we.
- Abort:
  - Abort has priority over any beat in the same cycle; that beat is not accepted.
  - Writes already registered complete; no further writes follow.
  - Next cycle: state=IDLE, busy=0, loaded=0, no done pulse.
  - Abort in IDLE has no effect, except that start is suppressed in the same cycle.
- Gating:
  - ffn_valid_out = ffn_valid_in && loaded && !busy.
  - gate_drop = ffn_valid_in && !ffn_valid_out.
  - Blocked valids are not stored.
- Reset mid-load: all state is cleared; a new start is required.

Test Plan (EMB=2, FF=4 → 22 words, ADDR_W=5; W1 0-7, b1 8-11, W2 12-19, b2 20-21):
1. Reset, pulse start, s_valid=1 continuously with s_data=100+i → cfg_we high for 22 consecutive cycles beginning 2 cycles after start, cfg_addr 0..21, cfg_wdata 100..121. region reads 0 for 8 beats, 1 for 4, 2 for 8, 3 for 2. done pulses once with addr 21; busy=0 and loaded=1 on the following cycle.
2. Same stream with s_valid alternating 1/0 → identical addr/data sequence, cfg_we high only on the cycle after each accepted beat, done on addr 21.
3. Abort asserted the cycle the 11th beat is offered → s_ready=0 in that cycle, last write is addr 9, busy=0 and loaded=0 next cycle, no done. A new start restarts at addr 0.
4. ffn_valid_in=1 held throughout test 1 → ffn_valid_out=0 and gate_drop=1 until loaded rises, then ffn_valid_out=1 and gate_drop=0. A second start drops loaded and ffn_valid_out immediately on the next cycle.
5. start pulsed at beat 5 while busy → ignored, sequence continues to addr 21. start and abort together in IDLE → stays IDLE, busy=0.
6. rst_n driven low asynchronously mid-cycle at beat 12 → cfg_we, busy, loaded, region and s_ready go to 0 without waiting for a clock edge. After release, an extra s_valid produces no writes until start.
